timer_a_counter: RTL and testbench

Timer_A count core: consumes `TimerClock` from the Timer_A pre-divider, synchronizes it into the MCLK domain and runs the 16-bit TAxR counter in stop, up, continuous or up/down mode. It raises TAIFG on counter overflow and the TAxCTL interrupt request, exports the count-enable tick and a CCR0-equal pulse to the capture/compare units, and supports peripheral-bus writes to TAxR, TACLR and TAIFG.

---
 rtl/timer_a_counter_pkg.sv | 13 +
 rtl/timer_a_counter_if.sv | 30 +++
 rtl/timer_a_tick_sync.sv | 31 +++
 rtl/timer_a_counter.sv | 115 +++++++++++
 tb/tb_timer_a_counter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_a_counter_pkg.sv
// Shared Timer_A count-core definitions: mode encodings and counter width.
package timer_a_counter_pkg;

    localparam int TA_WIDTH = 16;

    typedef enum logic [1:0] {
        MC__STOP       = 2'b00,
        MC__UP         = 2'b01,
        MC__CONTINUOUS = 2'b10,
        MC__UPDOWN     = 2'b11
    } mc_e;

endpackage

// File: rtl/timer_a_counter_if.sv
// Register-bus and capture/compare-facing signals of the Timer_A count core.
interface timer_a_counter_if #(
    parameter int WIDTH = 16
);
    logic             TimerClock;
    logic [1:0]       MC;
    logic [WIDTH-1:0] TACCR0;
    logic             wTACLR;
    logic             wTAR;
    logic [WIDTH-1:0] TARin;
    logic             wTAIFG;
    logic             TAIFGin;
    logic             TAIE;
    logic [WIDTH-1:0] TAR;
    logic             dir;
    logic             tick;
    logic             EQU0;
    logic             TAIFG;
    logic             TAxIRQ;

    modport master (
        output TimerClock, MC, TACCR0, wTACLR, wTAR, TARin, wTAIFG, TAIFGin, TAIE,
        input  TAR, dir, tick, EQU0, TAIFG, TAxIRQ
    );

    modport slave (
        input  TimerClock, MC, TACCR0, wTACLR, wTAR, TARin, wTAIFG, TAIFGin, TAIE,
        output TAR, dir, tick, EQU0, TAIFG, TAxIRQ
    );
endinterface

// File: rtl/timer_a_tick_sync.sv
// Brings the divided TimerClock into the MCLK domain and emits a one-cycle
// tick per rising edge.
module timer_a_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tclk_i,
    output logic tick_o
);
    // sync_q[0..1] are the synchronizer stages, sync_q[2] is edge history.
    logic [2:0] sync_q;
    logic [1:0] vld_pipe_q;
    logic       armed_q;

    // After reset the edge detector stays disarmed until a genuine low level
    // has been seen, so a TimerClock already high at release is not a tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            vld_pipe_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], tclk_i};
            vld_pipe_q <= {vld_pipe_q[0], 1'b1};
            if (vld_pipe_q[1] && !sync_q[1])
                armed_q <= 1'b1;
        end
    end

    assign tick_o = armed_q & sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/timer_a_counter.sv
// Timer_A TAxR count core: stop/up/continuous/up-down counting, TAIFG,
// CCR0-equal pulse and bus writes to TAxR, TACLR and TAIFG.
module timer_a_counter
    import timer_a_counter_pkg::*;
#(
    parameter int WIDTH = TA_WIDTH
) (
    input  logic               MCLK,
    input  logic               reset,
    timer_a_counter_if.slave   bus
);
    logic             tick;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] tar_q, tar_d;
    logic             dir_q, dir_d;
    logic             ifg_q, ifg_d;
    logic             equ_q, equ_d;
    logic             hw_set;
    mc_e              mc;

    assign n  = bus.TACCR0;
    assign mc = mc_e'(bus.MC);

    timer_a_tick_sync u_tick_sync (
        .clk_i  (MCLK),
        .rst_ni (reset),
        .tclk_i (bus.TimerClock),
        .tick_o (tick)
    );

    always_comb begin
        tar_d  = tar_q;
        dir_d  = dir_q;
        hw_set = 1'b0;
        equ_d  = 1'b0;
        if (bus.wTACLR) begin
            tar_d = '0;
            dir_d = 1'b0;
        end else if (bus.wTAR) begin
            tar_d = bus.TARin;
        end else if (tick && (mc != MC__STOP)) begin
            case (mc)
                MC__UP: begin
                    // >= rather than == so a period shrunk below TAR still wraps
                    if (n == '0) begin
                        tar_d = '0;
                    end else if (tar_q >= n) begin
                        tar_d  = '0;
                        hw_set = 1'b1;
                    end else begin
                        tar_d = tar_q + 1'b1;
                    end
                end
                MC__CONTINUOUS: begin
                    tar_d  = tar_q + 1'b1;
                    hw_set = &tar_q;
                end
                MC__UPDOWN: begin
                    if (n == '0) begin
                        tar_d = '0;
                        dir_d = 1'b0;
                    end else if (!dir_q) begin
                        if (tar_q >= n) begin
                            tar_d = n - 1'b1;
                            dir_d = 1'b1;
                        end else begin
                            tar_d = tar_q + 1'b1;
                        end
                    end else begin
                        if (tar_q == '0) begin
                            tar_d = {{(WIDTH-1){1'b0}}, 1'b1};
                            dir_d = 1'b0;
                        end else begin
                            tar_d  = tar_q - 1'b1;
                            hw_set = (tar_q == {{(WIDTH-1){1'b0}}, 1'b1});
                        end
                    end
                end
                default: ;
            endcase
            equ_d = (n != '0) && (tar_d == n);
        end
        if (mc != MC__UPDOWN)
            dir_d = 1'b0;
        // hardware set wins over a same-cycle software write
        if (hw_set)
            ifg_d = 1'b1;
        else if (bus.wTAIFG)
            ifg_d = bus.TAIFGin;
        else
            ifg_d = ifg_q;
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            tar_q <= '0;
            dir_q <= 1'b0;
            ifg_q <= 1'b0;
            equ_q <= 1'b0;
        end else begin
            tar_q <= tar_d;
            dir_q <= dir_d;
            ifg_q <= ifg_d;
            equ_q <= equ_d;
        end
    end

    assign bus.TAR    = tar_q;
    assign bus.dir    = dir_q;
    assign bus.tick   = tick;
    assign bus.EQU0   = equ_q;
    assign bus.TAIFG  = ifg_q;
    assign bus.TAxIRQ = ifg_q & bus.TAIE;

endmodule

// File: tb/tb_timer_a_counter.sv
// Directed bench for the Timer_A count core: one task per scenario.
module tb_timer_a_counter;
    localparam int WIDTH = 16;

    logic MCLK;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tick_cnt = 0;

    timer_a_counter_if #(.WIDTH(WIDTH)) bus ();

    timer_a_counter #(.WIDTH(WIDTH)) dut (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    always @(negedge MCLK) if (bus.tick === 1'b1) tick_cnt++;

    // One full TimerClock period (3 MCLK high, 3 low); state sampled just
    // after the update edge while EQU0 is still high.
    task automatic tc_pulse(output logic [15:0] t, output logic d, output logic e, output logic f);
        bus.TimerClock = 1'b1;
        repeat (3) @(posedge MCLK);
        #1;
        t = bus.TAR; d = bus.dir; e = bus.EQU0; f = bus.TAIFG;
        bus.TimerClock = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
    endtask

    task automatic do_wtar(input logic [15:0] v);
        bus.wTAR = 1'b1; bus.TARin = v;
        @(posedge MCLK); #1;
        bus.wTAR = 1'b0;
    endtask

    task automatic do_taclr();
        bus.wTACLR = 1'b1;
        @(posedge MCLK); #1;
        bus.wTACLR = 1'b0;
    endtask

    task automatic do_wtaifg(input logic v);
        bus.wTAIFG = 1'b1; bus.TAIFGin = v;
        @(posedge MCLK); #1;
        bus.wTAIFG = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.TimerClock = 1'b0; bus.MC = 2'b00; bus.TACCR0 = '0;
        bus.wTACLR = 1'b0; bus.wTAR = 1'b0; bus.TARin = '0;
        bus.wTAIFG = 1'b0; bus.TAIFGin = 1'b0; bus.TAIE = 1'b1;
        repeat (3) @(posedge MCLK);
        #1;
        n_tests++;
        if (bus.TAR !== 16'h0 || bus.dir !== 1'b0 || bus.tick !== 1'b0 ||
            bus.EQU0 !== 1'b0 || bus.TAIFG !== 1'b0 || bus.TAxIRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state TAR=%h dir=%b tick=%b EQU0=%b TAIFG=%b IRQ=%b expected all 0",
                     bus.TAR, bus.dir, bus.tick, bus.EQU0, bus.TAIFG, bus.TAxIRQ);
        end
        reset = 1'b1;
        repeat (5) @(posedge MCLK);
        #1;
    endtask

    task automatic test_up();
        logic [15:0] t; logic d, e, f;
        logic [15:0] et [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
        logic [4:0]  ee = 5'b01000;
        logic [4:0]  ef = 5'b10000;
        bus.MC = 2'b01; bus.TACCR0 = 16'd4; bus.TAIE = 1'b1;
        do_taclr();
        for (int i = 0; i < 5; i++) begin
            tc_pulse(t, d, e, f);
            n_tests++;
            if (t !== et[i] || e !== ee[i] || f !== ef[i]) begin
                n_fail++;
                $display("FAIL up_step%0d TAR=%h EQU0=%b TAIFG=%b expected %h %b %b",
                         i, t, e, f, et[i], ee[i], ef[i]);
            end
        end
        n_tests++;
        if (bus.TAxIRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL up_irq TAxIRQ=%b expected 1", bus.TAxIRQ);
        end
        do_wtaifg(1'b0);
        n_tests++;
        if (bus.TAIFG !== 1'b0 || bus.TAxIRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL up_clear TAIFG=%b IRQ=%b expected 0 0", bus.TAIFG, bus.TAxIRQ);
        end
    endtask

    task automatic test_continuous();
        logic [15:0] t; logic d, e, f;
        bus.MC = 2'b10; bus.TACCR0 = 16'hFFFE;
        do_wtar(16'hFFFE);
        n_tests++;
        if (bus.TAR !== 16'hFFFE || bus.EQU0 !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_load TAR=%h EQU0=%b expected fffe 0", bus.TAR, bus.EQU0);
        end
        tc_pulse(t, d, e, f);
        n_tests++;
        if (t !== 16'hFFFF || f !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_ffff TAR=%h TAIFG=%b expected ffff 0", t, f);
        end
        tc_pulse(t, d, e, f);
        n_tests++;
        if (t !== 16'h0000 || f !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_wrap TAR=%h TAIFG=%b expected 0000 1", t, f);
        end
        do_wtaifg(1'b0);
        n_tests++;
        if (bus.TAIFG !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_clear TAIFG=%b expected 0", bus.TAIFG);
        end
    endtask

    task automatic test_updown();
        logic [15:0] t; logic d, e, f;
        logic [15:0] et [7] = '{16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1};
        logic [6:0]  ed = 7'b0111000;
        logic [6:0]  ef = 7'b1100000;
        logic [6:0]  ee = 7'b0000100;
        bus.MC = 2'b11; bus.TACCR0 = 16'd3;
        do_taclr();
        for (int i = 0; i < 7; i++) begin
            tc_pulse(t, d, e, f);
            n_tests++;
            if (t !== et[i] || d !== ed[i] || e !== ee[i] || f !== ef[i]) begin
                n_fail++;
                $display("FAIL updown_step%0d TAR=%h dir=%b EQU0=%b TAIFG=%b expected %h %b %b %b",
                         i, t, d, e, f, et[i], ed[i], ee[i], ef[i]);
            end
        end
        do_wtaifg(1'b0);
    endtask

    task automatic test_stop();
        logic [15:0] t; logic d, e, f;
        int c0;
        bus.MC = 2'b00;
        do_wtar(16'd7);
        c0 = tick_cnt;
        tc_pulse(t, d, e, f);
        n_tests++;
        if (t !== 16'd7 || f !== 1'b0 || tick_cnt !== c0 + 1) begin
            n_fail++;
            $display("FAIL stop_hold TAR=%h TAIFG=%b ticks=%0d expected 0007 0 %0d",
                     t, f, tick_cnt, c0 + 1);
        end
    endtask

    task automatic test_shrink();
        logic [15:0] t; logic d, e, f;
        bus.MC = 2'b01; bus.TACCR0 = 16'd20;
        do_wtar(16'd10);
        bus.TACCR0 = 16'd5;
        tc_pulse(t, d, e, f);
        n_tests++;
        if (t !== 16'd0 || f !== 1'b1) begin
            n_fail++;
            $display("FAIL shrink TAR=%h TAIFG=%b expected 0000 1", t, f);
        end
        do_wtaifg(1'b0);
        bus.TACCR0 = 16'd0;
        for (int i = 0; i < 2; i++) begin
            tc_pulse(t, d, e, f);
            n_tests++;
            if (t !== 16'd0 || f !== 1'b0 || e !== 1'b0) begin
                n_fail++;
                $display("FAIL n0_step%0d TAR=%h TAIFG=%b EQU0=%b expected 0000 0 0", i, t, f, e);
            end
        end
    endtask

    task automatic test_collision();
        bus.MC = 2'b10; bus.TACCR0 = 16'h1234;
        do_wtar(16'hFFFF);
        bus.TimerClock = 1'b1;
        repeat (2) @(posedge MCLK);
        #1;
        n_tests++;
        if (bus.tick !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_tick tick=%b expected 1", bus.tick);
        end
        bus.wTAIFG = 1'b1; bus.TAIFGin = 1'b0;
        @(posedge MCLK); #1;
        bus.wTAIFG = 1'b0;
        n_tests++;
        if (bus.TAR !== 16'h0000 || bus.TAIFG !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_set_vs_clear TAR=%h TAIFG=%b expected 0000 1", bus.TAR, bus.TAIFG);
        end
        bus.TimerClock = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        bus.wTACLR = 1'b1; bus.wTAR = 1'b1; bus.TARin = 16'h5555;
        @(posedge MCLK); #1;
        bus.wTACLR = 1'b0; bus.wTAR = 1'b0;
        n_tests++;
        if (bus.TAR !== 16'h0000) begin
            n_fail++;
            $display("FAIL coll_clr_vs_wtar TAR=%h expected 0000", bus.TAR);
        end
        do_wtaifg(1'b0);
    endtask

    task automatic test_taclr();
        logic [15:0] t; logic d, e, f;
        bus.MC = 2'b10;
        do_wtar(16'h0123);
        do_wtaifg(1'b1);
        do_taclr();
        n_tests++;
        if (bus.TAR !== 16'h0000 || bus.dir !== 1'b0 || bus.TAIFG !== 1'b1) begin
            n_fail++;
            $display("FAIL taclr_cont TAR=%h dir=%b TAIFG=%b expected 0000 0 1",
                     bus.TAR, bus.dir, bus.TAIFG);
        end
        bus.MC = 2'b11; bus.TACCR0 = 16'd3;
        do_wtar(16'd3);
        tc_pulse(t, d, e, f);
        n_tests++;
        if (t !== 16'd2 || d !== 1'b1) begin
            n_fail++;
            $display("FAIL taclr_turn TAR=%h dir=%b expected 0002 1", t, d);
        end
        do_taclr();
        n_tests++;
        if (bus.TAR !== 16'h0000 || bus.dir !== 1'b0) begin
            n_fail++;
            $display("FAIL taclr_dir TAR=%h dir=%b expected 0000 0", bus.TAR, bus.dir);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] t; logic d, e, f;
        int c0;
        bus.MC = 2'b10; bus.TAIE = 1'b1;
        do_wtar(16'h0040);
        do_wtaifg(1'b1);
        bus.TimerClock = 1'b1;
        @(posedge MCLK); #1;
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.TAR !== 16'h0 || bus.dir !== 1'b0 || bus.tick !== 1'b0 ||
            bus.EQU0 !== 1'b0 || bus.TAIFG !== 1'b0 || bus.TAxIRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid TAR=%h dir=%b tick=%b EQU0=%b TAIFG=%b IRQ=%b expected all 0",
                     bus.TAR, bus.dir, bus.tick, bus.EQU0, bus.TAIFG, bus.TAxIRQ);
        end
        repeat (2) @(posedge MCLK);
        #1;
        reset = 1'b1;
        c0 = tick_cnt;
        repeat (8) @(posedge MCLK);
        #1;
        n_tests++;
        if (bus.TAR !== 16'h0 || tick_cnt !== c0) begin
            n_fail++;
            $display("FAIL reset_no_tick TAR=%h ticks=%0d expected 0000 %0d", bus.TAR, tick_cnt, c0);
        end
        bus.TimerClock = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        tc_pulse(t, d, e, f);
        n_tests++;
        if (t !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_fresh_edge TAR=%h expected 0001", t);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_continuous();
        test_updown();
        test_stop();
        test_shrink();
        test_collision();
        test_taclr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
